// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns toggle-requested CPU register writes into timed HD44780 8-bit write cycles
module lcd_ctrl #(
  parameter int T_PWR_CYC  = 750000,
  parameter int T_AS_CYC   = 2,
  parameter int T_EN_CYC   = 12,
  parameter int T_H_CYC    = 2,
  parameter int T_EXEC_CYC = 2000,
  parameter int T_LONG_CYC = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] io_lcd_i,
  output logic        busy_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_blon_o
);
  localparam int M1 = T_PWR_CYC > T_LONG_CYC ? T_PWR_CYC : T_LONG_CYC;
  localparam int M2 = M1 > T_EXEC_CYC ? M1 : T_EXEC_CYC;
  localparam int M3 = M2 > T_EN_CYC ? M2 : T_EN_CYC;
  localparam int M4 = M3 > T_AS_CYC ? M3 : T_AS_CYC;
  localparam int MX = M4 > T_H_CYC ? M4 : T_H_CYC;
  localparam int CW = MX > 2 ? $clog2(MX) : 1;
  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, last;
  logic last_tog, long_f, pending, done;
  assign pending = io_lcd_i[30] ^ last_tog;
  assign lcd_rw_o = 1'b0;
  always_comb begin
    last = state == PWRUP ? CW'(T_PWR_CYC - 1) :
           state == SETUP ? CW'(T_AS_CYC - 1) :
           state == PULSE ? CW'(T_EN_CYC - 1) :
           state == HOLD  ? CW'(T_H_CYC - 1) :
           long_f         ? CW'(T_LONG_CYC - 1) : CW'(T_EXEC_CYC - 1);
    done = cnt == last;
    state_n = state;
    case (state)
      PWRUP:   if (done) state_n = IDLE;
      IDLE:    if (pending) state_n = SETUP;
      SETUP:   if (done) state_n = PULSE;
      PULSE:   if (done) state_n = HOLD;
      HOLD:    if (done) state_n = EXEC;
      default: if (done) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= PWRUP;
      cnt        <= '0;
      last_tog   <= 1'b0;
      long_f     <= 1'b0;
      lcd_data_o <= 8'h00;
      lcd_rs_o   <= 1'b0;
      lcd_en_o   <= 1'b0;
      lcd_on_o   <= 1'b0;
      lcd_blon_o <= 1'b0;
      busy_o     <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      lcd_en_o   <= state_n == PULSE;
      busy_o     <= state_n != IDLE || pending;
      lcd_on_o   <= io_lcd_i[31];
      lcd_blon_o <= io_lcd_i[29];
      if (state == IDLE && pending) begin
        last_tog   <= io_lcd_i[30];
        lcd_rs_o   <= io_lcd_i[8];
        lcd_data_o <= io_lcd_i[7:0];
        long_f     <= !io_lcd_i[8] && io_lcd_i[7:2] == 6'd0 && io_lcd_i[1:0] != 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed and random LCD writes checked against a timeline model of the write cycle
module tb_lcd_ctrl;
  localparam int TPW = 10, TAS = 2, TEN = 12, TH = 2, TEX = 20, TLG = 50;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] io = '0;
  logic busy, rs, rw, en, on, blon;
  logic [7:0] data;
  lcd_ctrl #(.T_PWR_CYC(TPW), .T_EXEC_CYC(TEX), .T_LONG_CYC(TLG)) dut (
    .clk_i(clk), .rst_i(rst), .io_lcd_i(io), .busy_o(busy), .lcd_data_o(data),
    .lcd_rs_o(rs), .lcd_rw_o(rw), .lcd_en_o(en), .lcd_on_o(on), .lcd_blon_o(blon)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, k = 0, idle_at = 0, acc = -1000;
  int rises[$];
  logic m_tog = 0, m_rs = 0, e_on = 0, e_bl = 0, e_busy = 1, e_en = 0, pend, en_q = 0;
  logic [7:0] m_data = 0;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %0h want %0h", tag, k, obs, exp);
  endtask
  // the model tracks when the block next becomes idle and when the last write was accepted
  task automatic tick();
    @(posedge clk);
    k++;
    if (rst) begin
      idle_at = k + TPW; acc = -1000; m_tog = 0; m_rs = 0; m_data = 0;
      e_on = 0; e_bl = 0; e_busy = 1;
    end else begin
      pend = io[30] ^ m_tog;
      e_busy = (k < idle_at) || pend;
      if (k > idle_at && pend) begin
        acc = k; m_tog = io[30]; m_rs = io[8]; m_data = io[7:0];
        idle_at = k + TAS + TEN + TH + ((!m_rs && m_data inside {8'd1, 8'd2, 8'd3}) ? TLG : TEX);
      end
      e_on = io[31]; e_bl = io[29];
    end
    e_en = (k >= acc + TAS) && (k < acc + TAS + TEN);
    #1;
    check("busy", busy, e_busy);
    check("en", en, e_en);
    check("rs", rs, m_rs);
    check("data", data, m_data);
    check("rw", rw, 0);
    check("on", on, e_on);
    check("blon", blon, e_bl);
    if (en && !en_q) rises.push_back(k);
    en_q = en;
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic write(logic r, logic [7:0] d);
    io[30] = ~io[30]; io[8] = r; io[7:0] = d;
  endtask
  initial begin
    run(3);
    rst = 1'b0;
    run(15);
    io[31] = 1'b1;
    write(1'b1, 8'h41);
    check("io_word", io, 32'hC000_0141);
    run(40);
    write(1'b0, 8'h01);
    run(70);
    write(1'b0, 8'h38);
    run(40);
    rises.delete();
    write(1'b1, 8'h41);
    run(6);
    write(1'b1, 8'h42);
    run(80);
    check("en_gap", rises.size() >= 2 ? rises[1] - rises[0] : 0, TAS + TEN + TH + TEX + 1);
    check("second_data", data, 8'h42);
    rises.delete();
    write(1'b1, 8'h50);
    run(20);
    io[30] = ~io[30];
    run(1);
    io[30] = ~io[30];
    run(40);
    check("cancel_pulses", rises.size(), 1);
    check("cancel_busy", busy, 0);
    write(1'b1, 8'h33);
    run(6);
    rst = 1'b1;
    io[30] = 1'b0;
    run(1);
    check("rst_en", en, 0);
    rst = 1'b0;
    run(15);
    repeat (3000) begin
      rst = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) write(1'b0, 8'($urandom_range(0, 3)));
        else write(1'($urandom), 8'($urandom));
      end
      io[31] = 1'($urandom);
      io[29] = 1'($urandom);
      io[27:9] = 19'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
